// File: rtl/wb_stage.sv
// RV32I write-back: ALU results written 1 cycle after accept; loads held in LOAD_WAIT until dmem responds or times out.
// Backpressure: mem_ready_o is low while a load waits, so one non-load per cycle, loads block until completion.
module wb_stage #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic              mem_regwrite_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_is_load_i,
    input  logic [2:0]        mem_funct3_i,
    input  logic [1:0]        mem_addr_lo_i,
    input  logic [XLEN-1:0]   mem_alu_result_i,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              regwrite_o,
    output logic [REG_AW-1:0] write_register_o,
    output logic [XLEN-1:0]   write_data_o,
    output logic              load_fault_o,
    output logic              busy_o,
    output logic [31:0]       retire_cnt_o
);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t            state_q, state_d;
    logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
    logic              ld_rw_q, ld_rw_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [1:0]        ld_alo_q, ld_alo_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              regwrite_q, regwrite_d;
    logic [REG_AW-1:0] wreg_q, wreg_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic [31:0]       retire_cnt_q, retire_cnt_d;

    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [XLEN-1:0]   ext_v;
    logic              ld_bad;

    // Extraction and alignment check for the captured load, evaluated against the live response word.
    always_comb begin
        byte_v = dmem_rdata_i[{ld_alo_q, 3'b000} +: 8];
        half_v = dmem_rdata_i[{ld_alo_q[1], 4'b0000} +: 16];
        ext_v  = dmem_rdata_i;
        ld_bad = 1'b0;
        case (ld_f3_q)
            3'b000: ext_v = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b001: begin
                ext_v  = {{(XLEN-16){half_v[15]}}, half_v};
                ld_bad = ld_alo_q[0];
            end
            3'b010: ld_bad = (ld_alo_q != 2'b00);
            3'b100: ext_v = {{(XLEN-8){1'b0}}, byte_v};
            3'b101: begin
                ext_v  = {{(XLEN-16){1'b0}}, half_v};
                ld_bad = ld_alo_q[0];
            end
            default: ld_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ld_rd_d      = ld_rd_q;
        ld_rw_d      = ld_rw_q;
        ld_f3_d      = ld_f3_q;
        ld_alo_d     = ld_alo_q;
        tmo_d        = tmo_q;
        regwrite_d   = 1'b0;
        wreg_d       = wreg_q;
        wdata_d      = wdata_q;
        fault_d      = 1'b0;
        retire_cnt_d = retire_cnt_q;
        case (state_q)
            IDLE: begin
                // dmem_rvalid_i is deliberately ignored here: memory latency is at least one cycle.
                if (mem_valid_i) begin
                    if (mem_is_load_i) begin
                        ld_rd_d  = mem_rd_i;
                        ld_rw_d  = mem_regwrite_i;
                        ld_f3_d  = mem_funct3_i;
                        ld_alo_d = mem_addr_lo_i;
                        tmo_d    = 8'd0;
                        state_d  = LOAD_WAIT;
                    end else begin
                        regwrite_d   = mem_regwrite_i && (mem_rd_i != '0);
                        wreg_d       = mem_rd_i;
                        wdata_d      = mem_alu_result_i;
                        retire_cnt_d = retire_cnt_q + 32'd1;
                    end
                end
            end
            LOAD_WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                    if (ld_bad) begin
                        fault_d = 1'b1;
                    end else begin
                        regwrite_d   = ld_rw_q && (ld_rd_q != '0);
                        wreg_d       = ld_rd_q;
                        wdata_d      = ext_v;
                        retire_cnt_d = retire_cnt_q + 32'd1;
                    end
                end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ld_rd_q      <= '0;
            ld_rw_q      <= 1'b0;
            ld_f3_q      <= 3'b000;
            ld_alo_q     <= 2'b00;
            tmo_q        <= 8'd0;
            regwrite_q   <= 1'b0;
            wreg_q       <= '0;
            wdata_q      <= '0;
            fault_q      <= 1'b0;
            retire_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            ld_rd_q      <= ld_rd_d;
            ld_rw_q      <= ld_rw_d;
            ld_f3_q      <= ld_f3_d;
            ld_alo_q     <= ld_alo_d;
            tmo_q        <= tmo_d;
            regwrite_q   <= regwrite_d;
            wreg_q       <= wreg_d;
            wdata_q      <= wdata_d;
            fault_q      <= fault_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign mem_ready_o      = (state_q == IDLE);
    assign busy_o           = (state_q == LOAD_WAIT);
    assign regwrite_o       = regwrite_q;
    assign write_register_o = wreg_q;
    assign write_data_o     = wdata_q;
    assign load_fault_o     = fault_q;
    assign retire_cnt_o     = retire_cnt_q;

endmodule
